uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver. Consumes its rx_data / rx_data_valid / rx_data_ready handshake and stores bytes in a circular FIFO.
- Presents the bytes to the CPU-side register interface as first-word-fall-through (FWFT): the head byte is visible without a read cycle.
- Provides fill count, empty/full flags, a threshold interrupt and an optional overrun flag. Decouples line-rate reception from CPU polling latency.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 bytes); legal range 1..8.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- rx_data  input  8  byte from the UART receiver.
- rx_data_valid  input  1  receiver byte valid.
- rx_data_ready  output  1  FIFO accepts the byte this cycle.
- rd_en  input  1  CPU pop strobe, one pulse per byte.
- rd_data  output  8  head byte (FWFT).
- empty  output  1  FIFO holds 0 bytes.
- full  output  1  FIFO holds DEPTH bytes.
- count  output  DEPTH_LOG2+1  bytes stored, 0..DEPTH.
- irq_thresh  input  DEPTH_LOG2+1  interrupt threshold.
- irq  output  1  level interrupt.
- flush  input  1  synchronous clear.
- overrun  output  1  sticky overrun flag.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: rd_data=0, empty=1, full=0, count=0, irq=0, overrun=0, rx_data_ready=1. Pointers and count are cleared; memory contents are not reset.
- Storage: DEPTH x 8 register array with wr_ptr/rd_ptr, each DEPTH_LOG2 bits, wrapping modulo DEPTH. count is a separate registered counter; empty = (count==0) and full = (count==DEPTH), both registered/derived from count.
- Push: occurs when rx_data_valid && rx_data_ready at a clk edge. mem[wr_ptr] <= rx_data, wr_ptr+1, count+1.
- The receiver raises valid for exactly the cycle(s) it waits in its data-hold state. Each cycle with valid && ready counts as exactly one byte. The receiver drops valid on the edge after ready.
- Pop: occurs when rd_en && !empty. rd_ptr+1, count-1. rd_en while empty is ignored: no pointer change, no error.
- Read data: rd_data = mem[rd_ptr] when !empty, 8'h00 when empty (combinational from registered state). Latency from push to visible on rd_data: 1 cycle.
- Simultaneous push and pop (not empty): both pointers advance, count unchanged.
- Simultaneous push and pop while empty: pop ignored, push accepted, count becomes 1.
- Ready (macro off): rx_data_ready = !full. While full, the receiver stalls holding its byte. The byte is accepted the cycle after a pop makes full=0.
- irq = !empty && (count >= irq_thresh). irq_thresh=0 is treated as 1. Registered, updated one cycle after count changes.
- flush: highest priority over push and pop in the same cycle. Clears pointers and count (and overrun when the macro is enabled). A push presented in the flush cycle is discarded.
- Reset asserted mid-transfer: everything returns to reset values immediately. A byte in flight is lost.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap or bubble. A full DEPTH-deep fill then drain returns all bytes in order.

Optional Feature:
- Macro UART_RX_FIFO_OVERRUN_EN.
- Defined:
  - rx_data_ready tied to 1, so the receiver never stalls and never misses a start bit.
  - A push while full with no simultaneous pop discards the byte and sets overrun (sticky). FIFO contents and count are unchanged.
  - A push while full with a simultaneous pop is accepted normally; count stays DEPTH.
  - overrun_clr clears the flag; if an overrun event coincides with overrun_clr, the set wins.
- Undefined: behaviour as above with rx_data_ready = !full; overrun is tied to 0 and overrun_clr is ignored.

Test Plan:
- Reset, then push 0x41 -> next cycle empty=0, count=1, rd_data=0x41; rd_en pulse -> empty=1, rd_data=0x00.
- Push 16 bytes 0x00..0x0F (DEPTH_LOG2=4) -> full=1, count=16, rx_data_ready=0 (macro off). 17th byte 0xAA held by valid; one pop -> 0xAA accepted, count=16. Drain yields 0x01..0x0F, 0xAA in order.
- Push and rd_en in the same cycle with count=3 -> count stays 3, head advances. Same with count=0 -> count=1.
- irq_thresh=4: push 3 bytes -> irq=0; 4th byte -> irq=1 one cycle later; pop one -> irq=0.
- Macro on: fill 16, push 0x55 without pop -> overrun=1, count=16, 0x55 absent on drain. overrun_clr -> overrun=0.
- Fill 10, assert flush concurrently with a push -> count=0, empty=1, pushed byte absent. Assert rst_n=0 mid-fill -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: FWFT head byte, fill count, threshold irq.
// Define UART_RX_FIFO_OVERRUN_EN to never stall the receiver and flag dropped bytes in a sticky overrun bit.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  output logic                  rx_data_ready,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  input  logic [DEPTH_LOG2:0]   irq_thresh,
  output logic                  irq,
  input  logic                  flush,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  irq_q, irq_d;
  logic                  empty_w, full_w;
  logic                  push, pop;
  logic [CW-1:0]         thresh_eff;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_CNT);
  assign pop     = rd_en && !empty_w;

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d;
  logic ovr_evt;

  // A pop in the same cycle frees the slot, so a push while full is still legal then.
  assign rx_data_ready = 1'b1;
  assign push          = rx_data_valid && (!full_w || pop);
  assign ovr_evt       = rx_data_valid && full_w && !pop;

  always_comb begin
    overrun_d = overrun_q;
    if (flush)            overrun_d = 1'b0;
    else if (ovr_evt)     overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  logic unused_overrun_clr;

  assign rx_data_ready      = !full_w;
  assign push               = rx_data_valid && !full_w;
  assign overrun            = 1'b0;
  assign unused_overrun_clr = overrun_clr;
`endif

  assign thresh_eff = (irq_thresh == '0) ? CW'(1) : irq_thresh;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    irq_d    = !empty_w && (count_q >= thresh_eff);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  // Storage is deliberately left out of reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rd_data = empty_w ? 8'h00 : mem_q[rd_ptr_q];
  assign empty   = empty_w;
  assign full    = full_w;
  assign count   = count_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a negedge monitor checks every pop.
module tb_uart_rx_fifo;

  localparam int DL2 = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_data_valid;
  logic         rx_data_ready;
  logic         rd_en;
  logic [7:0]   rd_data;
  logic         empty;
  logic         full;
  logic [DL2:0] count;
  logic [DL2:0] irq_thresh;
  logic         irq;
  logic         flush;
  logic         overrun;
  logic         overrun_clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .irq_thresh(irq_thresh), .irq(irq), .flush(flush),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops happen at the next posedge when rd_en && !empty; the head byte must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_data: got 0x%0h with scoreboard empty at %0t", rd_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    exp_q.push_back(b);
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_data_valid = 1'b0; rd_en = 1'b0;
    irq_thresh = '0; flush = 1'b0; overrun_clr = 1'b0;
    repeat (3) tick();
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_empty",   empty, 1);
    check("rst_full",    full, 0);
    check("rst_count",   count, 0);
    check("rst_irq",     irq, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ready",   rx_data_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single byte; thresh 0 behaves as 1, irq trails count by a cycle.
    push_byte(8'h41);
    check("t1_empty", empty, 0);
    check("t1_count", count, 1);
    check("t1_rd_data", rd_data, 8'h41);
    check("t1_irq_lag", irq, 0);
    tick();
    check("t1_irq_thresh0", irq, 1);
    pop_n(1);
    check("t1_empty_after", empty, 1);
    check("t1_rd_data_empty", rd_data, 8'h00);
    pop_n(1);
    check("t1_pop_empty_count", count, 0);

    // Fill to full across the pointer wrap.
    irq_thresh = 5'd16;
    rx_data_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    rx_data_valid = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    check("fill_rd_data", rd_data, 8'h00);
`ifdef UART_RX_FIFO_OVERRUN_EN
    check("fill_ready_ovr", rx_data_ready, 1);
    rx_data = 8'h55; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
    check("ovr_flag", overrun, 1);
    check("ovr_count", count, 16);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    rx_data = 8'hAA; rx_data_valid = 1'b1; rd_en = 1'b1;
    exp_q.push_back(8'hAA);
    tick();
    rx_data_valid = 1'b0; rd_en = 1'b0;
    check("ovr_pushpop_count", count, 16);
`else
    check("fill_ready", rx_data_ready, 0);
    rx_data = 8'hAA; rx_data_valid = 1'b1;
    exp_q.push_back(8'hAA);
    repeat (2) tick();
    check("stall_count", count, 16);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("stall_after_pop_count", count, 15);
    check("stall_after_pop_ready", rx_data_ready, 1);
    tick();
    rx_data_valid = 1'b0;
    check("stall_accept_count", count, 16);
    check("no_overrun", overrun, 0);
`endif
    pop_n(16);
    check("drain_empty", empty, 1);
    check("drain_q", exp_q.size(), 0);

    // Simultaneous push and pop at count 3 and at count 0.
    push_byte(8'h10); push_byte(8'h11); push_byte(8'h12);
    rx_data = 8'h13; rx_data_valid = 1'b1; rd_en = 1'b1;
    exp_q.push_back(8'h13);
    tick();
    rx_data_valid = 1'b0; rd_en = 1'b0;
    check("pp3_count", count, 3);
    check("pp3_head", rd_data, 8'h11);
    pop_n(3);
    rx_data = 8'h20; rx_data_valid = 1'b1; rd_en = 1'b1;
    exp_q.push_back(8'h20);
    tick();
    rx_data_valid = 1'b0; rd_en = 1'b0;
    check("pp0_count", count, 1);
    check("pp0_head", rd_data, 8'h20);
    pop_n(1);

    // Threshold interrupt at 4.
    irq_thresh = 5'd4;
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    tick();
    check("irq_below", irq, 0);
    push_byte(8'h64);
    check("irq_lag", irq, 0);
    tick();
    check("irq_at_thresh", irq, 1);
    pop_n(1);
    tick();
    check("irq_after_pop", irq, 0);
    pop_n(3);

    // Flush beats a concurrent push.
    irq_thresh = 5'd16;
    for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i));
    check("flush_pre_count", count, 10);
    rx_data = 8'hEE; rx_data_valid = 1'b1; flush = 1'b1;
    tick();
    rx_data_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_rd_data", rd_data, 8'h00);
    push_byte(8'h77);
    check("flush_next_head", rd_data, 8'h77);
    pop_n(1);

    // Asynchronous reset in the middle of a fill.
    irq_thresh = 5'd2;
    for (int i = 0; i < 5; i++) push_byte(8'h90 + 8'(i));
    tick();
    check("prerst_irq", irq, 1);
    rx_data = 8'h99; rx_data_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_rd_data", rd_data, 8'h00);
    check("arst_irq", irq, 0);
    check("arst_ready", rx_data_ready, 1);
    check("arst_overrun", overrun, 0);
    rx_data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_count", count, 0);
    check("end_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
